// File: rtl/sao_stat_accum.sv
// sao_stat_accum: per-CTB saturating SAO category sum/count accumulator with serial drain
module sao_stat_accum #(
  parameter int diff_clip_bit = 4,
  parameter int N_CATE = 4,
  parameter int SUM_W = 18,
  parameter int CNT_W = 13
) (
  input  logic                               clk,
  input  logic                               arst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_first,
  input  logic                               in_last,
  input  logic signed [diff_clip_bit+3:0]    s71 [N_CATE],
  input  logic [2:0]                         n71 [N_CATE],
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(N_CATE)-1:0]          out_idx,
  output logic signed [SUM_W-1:0]            out_sum,
  output logic [CNT_W-1:0]                   out_cnt,
  output logic                               err
);
  localparam int XW = $clog2(N_CATE);
  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;
  state_t state;
  logic [XW-1:0] idx;
  logic signed [SUM_W-1:0] acc_sum [N_CATE];
  logic [CNT_W-1:0] acc_cnt [N_CATE];
  logic take, load, done;
  assign in_ready = state != DRAIN;
  assign take = in_valid && in_ready;
  assign load = take && (state == ACC || in_first);
  assign done = state == DRAIN && out_ready && idx == XW'(N_CATE - 1);
  assign out_valid = state == DRAIN;
  assign out_idx = idx;
  assign out_sum = acc_sum[idx];
  assign out_cnt = acc_cnt[idx];
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      idx <= '0;
      err <= 1'b0;
    end else begin
      err <= take && (state == IDLE ? !in_first : in_first);
      state <= load ? (in_last ? DRAIN : ACC) : done ? IDLE : state;
      if (state == DRAIN && out_ready) idx <= done ? '0 : idx + XW'(1);
    end
  end
  for (genvar k = 0; k < N_CATE; k++) begin : g_cate
    logic signed [SUM_W:0] base, ext, sw;
    logic [CNT_W:0] cw;
    logic signed [SUM_W-1:0] ns;
    logic [CNT_W-1:0] nc;
    // sum at SUM_W+1 bits so overflow shows as disagreeing top two bits
    always_comb begin
      base = acc_sum[k];
      ext = s71[k];
      sw = (in_first ? (SUM_W+1)'(0) : base) + ext;
      cw = (in_first ? (CNT_W+1)'(0) : {1'b0, acc_cnt[k]}) + {{(CNT_W-2){1'b0}}, n71[k]};
      ns = sw[SUM_W] != sw[SUM_W-1] ? {sw[SUM_W], {(SUM_W-1){~sw[SUM_W]}}} : sw[SUM_W-1:0];
      nc = cw[CNT_W] ? '1 : cw[CNT_W-1:0];
    end
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        acc_sum[k] <= '0;
        acc_cnt[k] <= '0;
      end else if (done) begin
        acc_sum[k] <= '0;
        acc_cnt[k] <= '0;
      end else if (load) begin
        acc_sum[k] <= ns;
        acc_cnt[k] <= nc;
      end
    end
  end
endmodule

// File: tb/tb_sao_stat_accum.sv
// tb_sao_stat_accum: directed checks of accumulate, drain, backpressure, saturation, errors, reset
module tb_sao_stat_accum;
  logic clk = 1'b0, arst_n = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic signed [7:0] s71 [4];
  logic [2:0] n71 [4];
  logic in_ready, out_valid, err, in_ready2, out_valid2, err2;
  logic [1:0] out_idx, out_idx2;
  logic signed [17:0] out_sum;
  logic [12:0] out_cnt;
  logic signed [7:0] out_sum2;
  logic [3:0] out_cnt2;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  sao_stat_accum dut (.clk(clk), .arst_n(arst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .s71(s71), .n71(n71), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_sum(out_sum), .out_cnt(out_cnt), .err(err));

  sao_stat_accum #(.SUM_W(8), .CNT_W(4)) dut_sat (.clk(clk), .arst_n(arst_n), .in_valid(in_valid),
    .in_ready(in_ready2), .in_first(in_first), .in_last(in_last), .s71(s71), .n71(n71),
    .out_valid(out_valid2), .out_ready(out_ready), .out_idx(out_idx2), .out_sum(out_sum2),
    .out_cnt(out_cnt2), .err(err2));

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int s0, s1, s2, s3, input int n0, n1, n2, n3);
    s71[0] = 8'(s0); s71[1] = 8'(s1); s71[2] = 8'(s2); s71[3] = 8'(s3);
    n71[0] = 3'(n0); n71[1] = 3'(n1); n71[2] = 3'(n2); n71[3] = 3'(n3);
  endtask

  task automatic beat(input bit f, l, input int s0, s1, s2, s3, input int n0, n1, n2, n3);
    set_in(s0, s1, s2, s3, n0, n1, n2, n3);
    in_valid = 1'b1; in_first = f; in_last = l;
    step();
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic pair(input int i, input int s, c, input int s2, c2);
    chk("out_valid", 32'(out_valid), 1);
    chk("in_ready_drain", 32'(in_ready), 0);
    chk("out_idx", 32'(out_idx), i);
    chk("out_sum", out_sum, s);
    chk("out_cnt", 32'(out_cnt), c);
    chk("sat_out_idx", 32'(out_idx2), i);
    chk("sat_out_sum", out_sum2, s2);
    chk("sat_out_cnt", 32'(out_cnt2), c2);
    step();
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cnt", 32'(out_cnt), 0);
    chk("rst_err", 32'(err), 0);
    step();
    arst_n = 1'b1;
    out_ready = 1'b1;
    step();

    beat(1, 1, 5, -3, 0, 105, 1, 2, 0, 7);
    pair(0, 5, 1, 5, 1);
    pair(1, -3, 2, -3, 2);
    pair(2, 0, 0, 0, 0);
    pair(3, 105, 7, 105, 7);
    chk("single_in_ready_back", 32'(in_ready), 1);
    chk("single_out_valid_low", 32'(out_valid), 0);

    beat(1, 0, 10, 0, 0, 0, 2, 0, 0, 0);
    step(); step();
    beat(0, 0, 10, 0, 0, 0, 2, 0, 0, 0);
    chk("bubble_no_valid", 32'(out_valid), 0);
    step(); step();
    beat(0, 1, 10, 0, 0, 0, 2, 0, 0, 0);
    pair(0, 30, 6, 30, 6);
    pair(1, 0, 0, 0, 0);
    pair(2, 0, 0, 0, 0);
    pair(3, 0, 0, 0, 0);

    out_ready = 1'b0;
    beat(1, 1, 1, 2, 3, 4, 1, 1, 1, 1);
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
    set_in(50, 50, 50, 50, 5, 5, 5, 5);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_idx", 32'(out_idx), 0);
      chk("bp_sum", out_sum, 1);
      chk("bp_cnt", 32'(out_cnt), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      step();
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    pair(0, 1, 1, 1, 1);
    pair(1, 2, 1, 2, 1);
    pair(2, 3, 1, 3, 1);
    pair(3, 4, 1, 4, 1);

    beat(1, 0, 105, -112, 0, 0, 7, 7, 0, 0);
    beat(0, 0, 105, -112, 0, 0, 7, 7, 0, 0);
    beat(0, 1, 0, 0, 0, 0, 7, 0, 0, 0);
    pair(0, 210, 21, 127, 15);
    pair(1, -224, 14, -128, 14);
    pair(2, 0, 0, 0, 0);
    pair(3, 0, 0, 0, 0);

    beat(0, 0, 9, 9, 9, 9, 1, 1, 1, 1);
    chk("idle_err", 32'(err), 1);
    chk("idle_err_ready", 32'(in_ready), 1);
    chk("idle_err_valid", 32'(out_valid), 0);
    chk("idle_err_sum", out_sum, 0);
    chk("idle_err_cnt", 32'(out_cnt), 0);
    step();
    chk("err_one_cycle", 32'(err), 0);
    beat(1, 0, 20, 0, 0, 0, 1, 0, 0, 0);
    chk("first_no_err", 32'(err), 0);
    beat(1, 1, 7, 0, 0, 0, 2, 0, 0, 0);
    chk("restart_err", 32'(err), 1);
    pair(0, 7, 2, 7, 2);
    pair(1, 0, 0, 0, 0);
    pair(2, 0, 0, 0, 0);
    pair(3, 0, 0, 0, 0);

    beat(1, 1, 11, 22, 33, 44, 1, 2, 3, 4);
    pair(0, 11, 1, 11, 1);
    pair(1, 22, 2, 22, 2);
    chk("pre_rst_idx", 32'(out_idx), 2);
    #2 arst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_idx", 32'(out_idx), 0);
    chk("midrst_sum", out_sum, 0);
    chk("midrst_ready", 32'(in_ready), 1);
    step();
    arst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(out_valid), 0);
    beat(1, 1, -1, -2, -3, -4, 3, 3, 3, 3);
    pair(0, -1, 3, -1, 3);
    pair(1, -2, 3, -2, 3);
    pair(2, -3, 3, -3, 3);
    pair(3, -4, 3, -4, 3);
    chk("end_in_ready", 32'(in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sao_stat_accum.md
# sao_stat_accum

Per-CTB accumulator for SAO statistics, sitting directly downstream of the 7-pixel category-sum adders. Each cycle it takes one beat of per-category partial sums and match counts (signed 7-pixel diff sums plus 0..7 counts) for N_CATE categories. It accumulates them over a whole CTB into saturating sum/count registers. At CTB end it drains the N_CATE (sum, count) pairs one per handshake to the offset-decision stage.

## Interface
- diff_clip_bit, 4: clipped diff magnitude bits; upstream partial sum width is diff_clip_bit+4 (signed)
- N_CATE, 4: number of categories accumulated in parallel (≥2)
- SUM_W, 18: signed accumulator width per category
- CNT_W, 13: unsigned count width per category (4096 pixels/CTB)
- clk  in  1  clock, all state rising-edge
- arst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_first  in  1  beat is first of a CTB
- in_last  in  1  beat is last of a CTB
- s71  in  signed [diff_clip_bit+3:0] x [0:N_CATE-1]  per-category partial sum
- n71  in  [2:0] x [0:N_CATE-1]  per-category match count, 0..7
- out_valid  out  1  result pair valid
- out_ready  in  1  downstream accepts result
- out_idx  out  [$clog2(N_CATE)-1:0]  category index of current result
- out_sum  out  signed [SUM_W-1:0]  accumulated sum
- out_cnt  out  [CNT_W-1:0]  accumulated count
- err  out  1  one-cycle protocol-error pulse

## Operation
- FSM states: IDLE, ACC, DRAIN; reset state IDLE.
- in_ready = 1 in IDLE and ACC, 0 in DRAIN. Beats presented during DRAIN are not accepted.
- IDLE, accepted beat with in_first=1: load acc_sum[k]=sext(s71[k]), acc_cnt[k]=n71[k]. Next state ACC, or DRAIN if in_last=1 as well.
- IDLE, accepted beat with in_first=0: beat dropped, err pulses, stay IDLE.
- ACC, accepted beat with in_first=0: acc_sum[k]+=s71[k] and acc_cnt[k]+=n71[k]. Go to DRAIN if in_last=1.
- ACC, accepted beat with in_first=1: err pulses, accumulators are reloaded as in IDLE (restart), and in_last is honoured.
- Sum arithmetic: add at SUM_W+1 bits, then saturate to [-2^(SUM_W-1), 2^(SUM_W-1)-1].
- Count arithmetic: saturates at 2^CNT_W-1.
- DRAIN: out_valid=1. out_idx starts at 0 and increments on each out_valid && out_ready. out_sum and out_cnt are acc_sum[out_idx] and acc_cnt[out_idx].
- Handshake at out_idx=N_CATE-1: accumulators clear to 0, out_idx returns to 0, next state IDLE.
- out_valid, out_idx, out_sum and out_cnt hold stable while out_valid && !out_ready.

## Timing
- Reset values (asserted immediately on arst_n low):
  - state IDLE, so in_ready=1
  - out_valid=0, out_idx=0, out_sum=0, out_cnt=0
  - err=0, all accumulators 0
- Accumulate latency: one cycle; an accepted beat's contribution is visible in acc registers the next cycle.
- in_last beat accepted at cycle t gives out_valid=1 at t+1, with out_idx 0 carrying the totals including that beat.
- Drain with out_ready held 1 takes exactly N_CATE cycles. in_ready returns to 1 the cycle after the final handshake.
- in_first of the next CTB can therefore be accepted N_CATE+1 cycles after the last beat at the earliest.
- err is registered and pulses in the cycle after the offending beat.
- out_sum and out_cnt are driven from registers through the index mux only; there is no combinational path from in_* to out_*.
- arst_n asserted mid-ACC or mid-DRAIN aborts the CTB. No partial result is emitted after release.

## Test plan
- Single-beat CTB: in_first=in_last=1, s71={5,-3,0,105}, n71={1,2,0,7}, out_ready=1 → out_valid from next cycle. Results (idx,sum,cnt) = (0,5,1), (1,-3,2), (2,0,0), (3,105,7) on 4 consecutive cycles, then in_ready=1.
- Multi-beat with bubbles: 3 beats with s71[0]=10, n71[0]=2, other categories 0, in_valid low 2 cycles between beats → idx0 gives sum 30, cnt 6; other categories give 0/0.
- Backpressure: out_ready=0 for 5 cycles in DRAIN → out_idx=0 and out_sum/out_cnt stable, in_ready=0, in_valid beats ignored. Raising out_ready resumes the drain from idx 0.
- Saturation with SUM_W=8: two beats s71[0]=105 → out_sum 127; two beats s71[1]=-112 → out_sum -128.
- Protocol errors:
  - Beat with in_first=0 in IDLE → err pulse, state and accumulators unchanged.
  - In ACC after s71[0]=20, a beat with in_first=1, in_last=1, s71[0]=7 → err pulse, drained idx0 sum 7.
- Reset mid-drain: drop arst_n at out_idx=2 → out_valid=0 immediately. After release, in_ready=1 and a new single-beat CTB drains correct values with no residue from the aborted CTB.
